// File: rtl/btb_assoc.sv
// Set-associative tagged BTB with tree pseudo-LRU replacement and a one-set-per-cycle flush walker.
// Latency: lookup is combinational from registered state (0 cycles); an accepted update is visible the next cycle.
// Backpressure: none; updates are silently dropped in debug mode, during a flush, or alongside flush_i.
module btb_assoc #(
    parameter int unsigned NR_SETS         = 16,
    parameter int unsigned NR_WAYS         = 4,
    parameter int unsigned TAG_BITS        = 8,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter bit          RVC             = 1'b1,
    parameter int unsigned VLEN            = 39
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            debug_mode_i,
    input  logic [VLEN-1:0]                 vpc_i,
    input  logic                            btb_update_valid_i,
    input  logic [VLEN-1:0]                 btb_update_pc_i,
    input  logic [VLEN-1:0]                 btb_update_target_i,
    output logic [INSTR_PER_FETCH-1:0]      btb_prediction_valid_o,
    output logic [INSTR_PER_FETCH*VLEN-1:0] btb_prediction_target_o,
    output logic                            flush_busy_o
);

    localparam int unsigned OFFSET    = RVC ? 1 : 2;
    localparam int unsigned LANE_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned SET_BITS  = $clog2(NR_SETS);
    localparam int unsigned WAY_BITS  = $clog2(NR_WAYS);
    localparam int unsigned SET_LSB   = OFFSET + LANE_BITS;
    localparam int unsigned TAG_LSB   = SET_LSB + SET_BITS;

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e                state_q;
    logic [SET_BITS-1:0]   flush_cnt_q;
    logic [NR_WAYS-1:0]    valid_q  [NR_SETS];
    logic [NR_WAYS-2:0]    plru_q   [NR_SETS];
    logic [TAG_BITS-1:0]   tag_q    [NR_SETS][NR_WAYS];
    logic [LANE_BITS-1:0]  lane_q   [NR_SETS][NR_WAYS];
    logic [VLEN-1:0]       target_q [NR_SETS][NR_WAYS];

    // Address fields of the fetch PC and of the update PC.
    logic [SET_BITS-1:0]  rd_set, up_set;
    logic [TAG_BITS-1:0]  rd_tag, up_tag;
    logic [LANE_BITS-1:0] up_lane;
    logic                 unused_pc;

    assign rd_set    = vpc_i[SET_LSB +: SET_BITS];
    assign rd_tag    = vpc_i[TAG_LSB +: TAG_BITS];
    assign up_set    = btb_update_pc_i[SET_LSB +: SET_BITS];
    assign up_tag    = btb_update_pc_i[TAG_LSB +: TAG_BITS];
    assign up_lane   = btb_update_pc_i[OFFSET +: LANE_BITS];
    assign unused_pc = ^{vpc_i, btb_update_pc_i};

    assign flush_busy_o = (state_q == FLUSH);

    // Per-lane lookup: descending way scan so the lowest matching way wins; forced off while flushing.
    always_comb begin
        btb_prediction_valid_o  = '0;
        btb_prediction_target_o = '0;
        for (int l = 0; l < int'(INSTR_PER_FETCH); l++) begin
            for (int w = int'(NR_WAYS) - 1; w >= 0; w--) begin
                if (state_q == IDLE && valid_q[rd_set][w] && tag_q[rd_set][w] == rd_tag &&
                    lane_q[rd_set][w] == LANE_BITS'(l)) begin
                    btb_prediction_valid_o[l]                 = 1'b1;
                    btb_prediction_target_o[l*VLEN +: VLEN]   = target_q[rd_set][w];
                end
            end
        end
    end

    // Update way selection: matching entry, else lowest invalid way, else PLRU victim; then the new tree bits.
    logic                 up_accept;
    logic                 hit_any, inv_any;
    logic [WAY_BITS-1:0]  hit_way, inv_way, vic_way, upd_way, node;
    logic [NR_WAYS-2:0]   plru_d;
    logic                 dir;

    assign up_accept = btb_update_valid_i && !debug_mode_i && (state_q == IDLE) && !flush_i;

    always_comb begin
        hit_any = 1'b0;
        inv_any = 1'b0;
        hit_way = '0;
        inv_way = '0;
        vic_way = '0;
        node    = '0;
        dir     = 1'b0;
        for (int w = int'(NR_WAYS) - 1; w >= 0; w--) begin
            if (valid_q[up_set][w] && tag_q[up_set][w] == up_tag && lane_q[up_set][w] == up_lane) begin
                hit_any = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid_q[up_set][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_BITS'(w);
            end
        end
        // Walk the tree: a node bit of 0 sends the victim to the left subtree.
        for (int lvl = 0; lvl < int'(WAY_BITS); lvl++) begin
            dir                        = plru_q[up_set][node];
            vic_way[WAY_BITS-1-lvl]    = dir;
            node                       = (node << 1) + WAY_BITS'(1) + WAY_BITS'(dir);
        end
        upd_way = hit_any ? hit_way : (inv_any ? inv_way : vic_way);
        // Touch the written way: every node on its path points to the opposite subtree.
        plru_d = plru_q[up_set];
        node   = '0;
        for (int lvl = 0; lvl < int'(WAY_BITS); lvl++) begin
            dir          = upd_way[WAY_BITS-1-lvl];
            plru_d[node] = ~dir;
            node         = (node << 1) + WAY_BITS'(1) + WAY_BITS'(dir);
        end
    end

    // Flush walker FSM and table storage: one set cleared per FLUSH cycle, updates only in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            for (int s = 0; s < int'(NR_SETS); s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < int'(NR_WAYS); w++) begin
                    tag_q[s][w]    <= '0;
                    lane_q[s][w]   <= '0;
                    target_q[s][w] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= '0;
                    end else if (up_accept) begin
                        valid_q[up_set][upd_way]  <= 1'b1;
                        tag_q[up_set][upd_way]    <= up_tag;
                        lane_q[up_set][upd_way]   <= up_lane;
                        target_q[up_set][upd_way] <= btb_update_target_i;
                        plru_q[up_set]            <= plru_d;
                    end
                end
                FLUSH: begin
                    valid_q[flush_cnt_q] <= '0;
                    plru_q[flush_cnt_q]  <= '0;
                    if (flush_i) begin
                        flush_cnt_q <= '0;
                    end else if (flush_cnt_q == SET_BITS'(NR_SETS - 1)) begin
                        state_q     <= IDLE;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + SET_BITS'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
